// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_pkg
//  Description : Shared types and constants for the frequency-sweep scheduler.
//                Build option: SWEEP_EXT_ADV_EN (external dwell advance).
//  Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    // Power-on divider values for the dual-tone generator.
    localparam logic [15:0] c_fc1_def = 16'd52;
    localparam logic [15:0] c_fc2_def = 16'd1562;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        DWELL  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // One table entry: high-tone and low-tone divider pair.
    typedef struct packed {
        logic [15:0] fc1;
        logic [15:0] fc2;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_ctrl_if
//  Description : Control, configuration and generator-facing signals of the
//                sweep scheduler. SWEEP_EXT_ADV_EN adds the 'adv' input.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sweep_ctrl_if #(
    parameter int AW      = 3,
    parameter int DWELL_W = 24
);
    // Sweep control
    logic               start;
    logic               abort;
    logic               loop_en;
    logic [AW-1:0]      last_idx;
    logic [DWELL_W-1:0] dwell_len;
`ifdef SWEEP_EXT_ADV_EN
    logic               adv;
`endif

    // Table configuration
    logic               cfg_we;
    logic [AW-1:0]      cfg_addr;
    logic [15:0]        cfg_fc1;
    logic [15:0]        cfg_fc2;

    // Generator and capture side
    logic [15:0]        fre_cnt1;
    logic [15:0]        fre_cnt2;
    logic               gen_rst;
    logic               step_valid;
    logic [AW-1:0]      step_idx;
    logic               busy;
    logic               done;

    // Host / test side: drives control and configuration.
    modport master (
        output start, abort, loop_en, last_idx, dwell_len,
               cfg_we, cfg_addr, cfg_fc1, cfg_fc2,
`ifdef SWEEP_EXT_ADV_EN
        output adv,
`endif
        input  fre_cnt1, fre_cnt2, gen_rst, step_valid, step_idx, busy, done
    );

    // Scheduler side.
    modport slave (
        input  start, abort, loop_en, last_idx, dwell_len,
               cfg_we, cfg_addr, cfg_fc1, cfg_fc2,
`ifdef SWEEP_EXT_ADV_EN
        input  adv,
`endif
        output fre_cnt1, fre_cnt2, gen_rst, step_valid, step_idx, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/sweep_table.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_table
//  Description : DEPTH x 32 divider-pair register file. One synchronous write
//                port, one asynchronous read port. Reset restores defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_table
    import sweep_pkg::*;
#(
    parameter int          DEPTH   = 8,
    parameter int          AW      = 3,
    parameter logic [15:0] FC1_DEF = c_fc1_def,
    parameter logic [15:0] FC2_DEF = c_fc2_def
) (
    input  logic          clk_in,
    input  logic          reset_p,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    localparam entry_t c_def_entry = '{fc1: FC1_DEF, fc2: FC2_DEF};

    entry_t r_mem [DEPTH];

    // Storage: every entry returns to the default pair on reset.
    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= c_def_entry;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Combinational read so LOAD can register the entry in one cycle.
    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_ctrl
//  Description : Frequency-sweep scheduler for the dual-tone test generator.
//                Steps through a table of divider pairs, pulsing gen_rst for
//                SETTLE_CYC cycles per step, then opening a step_valid capture
//                window. Single-shot or looping.
//                Build option SWEEP_EXT_ADV_EN: the capture window ends on the
//                first cycle 'adv' is high instead of on a dwell count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter int          DWELL_W    = 24,
    parameter int          SETTLE_CYC = 4,
    parameter logic [15:0] FC1_DEF    = c_fc1_def,
    parameter logic [15:0] FC2_DEF    = c_fc2_def
) (
    input  logic        clk_in,
    input  logic        reset_p,
    sweep_ctrl_if.slave bus
);

    localparam int c_aw  = $clog2(DEPTH);
    // Settle counter counts SETTLE_CYC-1 down to 0.
    localparam int c_scw = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [c_scw-1:0] c_settle_ld = c_scw'(SETTLE_CYC - 1);

    state_t             r_state;
    logic [15:0]        r_fc1;
    logic [15:0]        r_fc2;
    logic               r_gen_rst;
    logic               r_step_valid;
    logic [c_aw-1:0]    r_step_idx;
    logic               r_busy;
    logic               r_done;
    logic               r_loop;
    logic [c_aw-1:0]    r_last;
    logic [c_scw-1:0]   r_settle_cnt;
`ifndef SWEEP_EXT_ADV_EN
    logic [DWELL_W-1:0] r_dwell_m1;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic [DWELL_W-1:0] w_dwell_m1;
`endif

    logic               w_start_ok;
    logic               w_tab_we;
    logic               w_dwell_end;
    entry_t             w_wdata;
    entry_t             w_rdata;

    // Abort in IDLE suppresses a simultaneous start.
    assign w_start_ok = bus.start && !bus.abort;

    // Table is frozen for the whole sweep so the running sequence is stable.
    assign w_tab_we   = bus.cfg_we && !r_busy;
    assign w_wdata    = '{fc1: bus.cfg_fc1, fc2: bus.cfg_fc2};

`ifdef SWEEP_EXT_ADV_EN
    assign w_dwell_end = bus.adv;
`else
    // A zero dwell length behaves as a single-cycle window.
    assign w_dwell_m1  = (bus.dwell_len == '0) ? '0 : (bus.dwell_len - 1'b1);
    assign w_dwell_end = (r_dwell_cnt == '0);
`endif

    sweep_table #(
        .DEPTH   (DEPTH),
        .AW      (c_aw),
        .FC1_DEF (FC1_DEF),
        .FC2_DEF (FC2_DEF)
    ) u_table (
        .clk_in  (clk_in),
        .reset_p (reset_p),
        .we      (w_tab_we),
        .waddr   (bus.cfg_addr),
        .wdata   (w_wdata),
        .raddr   (r_step_idx),
        .rdata   (w_rdata)
    );

    // Sequencer: walks the table, times settle/dwell windows, owns all outputs.
    always_ff @(posedge clk_in or posedge reset_p) begin
        if (reset_p) begin
            r_state      <= IDLE;
            r_fc1        <= FC1_DEF;
            r_fc2        <= FC2_DEF;
            r_gen_rst    <= 1'b0;
            r_step_valid <= 1'b0;
            r_step_idx   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_loop       <= 1'b0;
            r_last       <= '0;
            r_settle_cnt <= '0;
`ifndef SWEEP_EXT_ADV_EN
            r_dwell_m1   <= '0;
            r_dwell_cnt  <= '0;
`endif
        end else if (bus.abort && (r_state != IDLE)) begin
            // Abort wins over everything; dividers and index are left as-is.
            r_state      <= IDLE;
            r_gen_rst    <= 1'b0;
            r_step_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) begin
                        r_state    <= LOAD;
                        r_busy     <= 1'b1;
                        r_step_idx <= '0;
                        r_loop     <= bus.loop_en;
                        r_last     <= bus.last_idx;
`ifndef SWEEP_EXT_ADV_EN
                        r_dwell_m1 <= w_dwell_m1;
`endif
                    end
                end

                LOAD: begin
                    r_fc1        <= w_rdata.fc1;
                    r_fc2        <= w_rdata.fc2;
                    r_gen_rst    <= 1'b1;
                    r_settle_cnt <= c_settle_ld;
                    r_state      <= SETTLE;
                end

                SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_gen_rst    <= 1'b0;
                        r_step_valid <= 1'b1;
`ifndef SWEEP_EXT_ADV_EN
                        r_dwell_cnt  <= r_dwell_m1;
`endif
                        r_state      <= DWELL;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end

                DWELL: begin
                    if (w_dwell_end) begin
                        r_step_valid <= 1'b0;
                        if (r_step_idx != r_last) begin
                            r_step_idx <= r_step_idx + 1'b1;
                            r_state    <= LOAD;
                        end else if (r_loop) begin
                            r_step_idx <= '0;
                            r_state    <= LOAD;
                        end else begin
                            // Completion: busy drops together with the done pulse.
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= DONE;
                        end
                    end
`ifndef SWEEP_EXT_ADV_EN
                    else begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                    end
`endif
                end

                DONE: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.fre_cnt1   = r_fc1;
    assign bus.fre_cnt2   = r_fc2;
    assign bus.gen_rst    = r_gen_rst;
    assign bus.step_valid = r_step_valid;
    assign bus.step_idx   = r_step_idx;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sweep_ctrl
//  Description : Self-checking bench for sweep_ctrl. Expected outputs come
//                from a timeline model: cycle t after start maps to step
//                (t-1)/P and phase (t-1)%P with P = 1+SETTLE+dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_ctrl;
    import sweep_pkg::*;

    localparam int DEPTH      = 8;
    localparam int AW         = 3;
    localparam int DWELL_W    = 24;
    localparam int SETTLE_CYC = 4;

    logic clk_in  = 1'b0;
    logic reset_p = 1'b1;

    sweep_ctrl_if #(.AW(AW), .DWELL_W(DWELL_W)) bus();

    sweep_ctrl #(
        .DEPTH      (DEPTH),
        .DWELL_W    (DWELL_W),
        .SETTLE_CYC (SETTLE_CYC),
        .FC1_DEF    (16'd52),
        .FC2_DEF    (16'd1562)
    ) dut (
        .clk_in  (clk_in),
        .reset_p (reset_p),
        .bus     (bus)
    );

    always #10 clk_in = ~clk_in;

    typedef struct packed {
        logic [15:0]   fc1;
        logic [15:0]   fc2;
        logic          gen;
        logic          valid;
        logic [AW-1:0] idx;
        logic          busy;
        logic          done;
    } obs_t;

    int          errors = 0;
    int          checks = 0;

    // Reference model state
    logic [15:0] m_fc1 [DEPTH];
    logic [15:0] m_fc2 [DEPTH];
    int          m_last;
    int          m_dwell;
    bit          m_loop;
    logic [15:0] m_pfc1;
    logic [15:0] m_pfc2;
    obs_t        m_hold;

    function automatic obs_t dut_obs();
        obs_t o;
        o.fc1   = bus.fre_cnt1;
        o.fc2   = bus.fre_cnt2;
        o.gen   = bus.gen_rst;
        o.valid = bus.step_valid;
        o.idx   = bus.step_idx;
        o.busy  = bus.busy;
        o.done  = bus.done;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o     = '0;
        o.fc1 = 16'd52;
        o.fc2 = 16'd1562;
        return o;
    endfunction

    // Outputs seen just after edge t, where edge 0 samples start.
    function automatic obs_t exp_at(int t);
        obs_t o;
        int   plen, n, k, ph, e;
        plen = 1 + SETTLE_CYC + m_dwell;
        n    = m_last + 1;
        o    = '0;
        if (t == 0) begin
            o.fc1  = m_pfc1;
            o.fc2  = m_pfc2;
            o.busy = 1'b1;
        end else if (!m_loop && t >= n * plen) begin
            o.fc1  = m_fc1[m_last];
            o.fc2  = m_fc2[m_last];
            o.idx  = AW'(m_last);
            o.done = 1'(t == n * plen);
        end else begin
            k       = (t - 1) / plen;
            ph      = (t - 1) % plen;
            e       = k % n;
            o.fc1   = m_fc1[e];
            o.fc2   = m_fc2[e];
            o.gen   = 1'(ph < SETTLE_CYC);
            o.valid = 1'((ph >= SETTLE_CYC) && (ph < SETTLE_CYC + m_dwell));
            if (ph == plen - 1) o.idx = AW'((e == m_last) ? 0 : e + 1);
            else                o.idx = AW'(e);
            o.busy  = 1'b1;
        end
        return o;
    endfunction

    function automatic obs_t frozen(obs_t h);
        obs_t o;
        o       = h;
        o.gen   = 1'b0;
        o.valid = 1'b0;
        o.busy  = 1'b0;
        o.done  = 1'b0;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_quiet();
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.loop_en   = 1'b0;
        bus.last_idx  = '0;
        bus.dwell_len = '0;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_fc1   = '0;
        bus.cfg_fc2   = '0;
`ifdef SWEEP_EXT_ADV_EN
        bus.adv       = 1'b0;
`endif
    endtask

    // Random activity on inputs that a running sweep must ignore.
    task automatic noise();
        bus.start     = 1'($urandom);
        bus.loop_en   = 1'($urandom);
        bus.last_idx  = AW'($urandom);
        bus.dwell_len = DWELL_W'($urandom_range(0, 20));
        bus.cfg_we    = 1'($urandom);
        bus.cfg_addr  = AW'($urandom);
        bus.cfg_fc1   = 16'($urandom);
        bus.cfg_fc2   = 16'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_fc1[i] = 16'd52;
            m_fc2[i] = 16'd1562;
        end
        m_hold = reset_obs();
    endtask

    // Idle-time table write; the model follows it.
    task automatic write_entry(int a, logic [15:0] f1, logic [15:0] f2);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(a);
        bus.cfg_fc1  = f1;
        bus.cfg_fc2  = f2;
        tick();
        bus.cfg_we   = 1'b0;
        m_fc1[a]     = f1;
        m_fc2[a]     = f2;
    endtask

    // Presents start for one edge; afterwards the bench sits at t = 0.
    task automatic begin_sweep(int last, int dwell, bit lp);
        bus.last_idx  = AW'(last);
        bus.dwell_len = DWELL_W'(dwell);
        bus.loop_en   = lp;
        bus.start     = 1'b1;
        m_last        = last;
        m_dwell       = (dwell == 0) ? 1 : dwell;
        m_loop        = lp;
        m_pfc1        = m_hold.fc1;
        m_pfc2        = m_hold.fc2;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        drive_quiet();
        model_reset();
        reset_p = 1'b1;
        repeat (2) tick();
        o = dut_obs();
        checks++;
        if (o !== reset_obs()) begin
            errors++;
            $display("FAIL reset_state got %h exp %h", o, reset_obs());
        end
        reset_p = 1'b0;
        repeat (3) tick();
        o = dut_obs();
        checks++;
        if (o !== reset_obs()) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp %h", o, reset_obs());
        end
    endtask

    // Sweep the untouched table: every entry must read back the defaults.
    task automatic test_default_table();
        obs_t o, e;
        begin_sweep(7, 1, 1'b0);
        for (int t = 0; t <= 8 * 6 + 2; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL default_table t=%0d got %h exp %h", t, o, e);
            end
            m_hold = e;
        end
    endtask

    task automatic test_single_shot();
        obs_t o, e;
        int   done_cnt, done_t, gen_cnt, val_cnt;
        done_cnt = 0; done_t = -1; gen_cnt = 0; val_cnt = 0;
        write_entry(0, 16'd10, 16'd100);
        write_entry(1, 16'd20, 16'd200);
        write_entry(2, 16'd30, 16'd300);
        begin_sweep(2, 8, 1'b0);
        for (int t = 0; t <= 42; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL single_shot t=%0d got %h exp %h", t, o, e);
            end
            if (o.done) begin done_cnt++; done_t = t; end
            if (o.gen)   gen_cnt++;
            if (o.valid) val_cnt++;
            m_hold = e;
        end
        checks++;
        if (done_cnt !== 1 || done_t !== 39) begin
            errors++;
            $display("FAIL done_pulse count=%0d at=%0d exp count=1 at=39", done_cnt, done_t);
        end
        checks++;
        if (gen_cnt !== 12 || val_cnt !== 24) begin
            errors++;
            $display("FAIL window_lengths gen=%0d valid=%0d exp gen=12 valid=24", gen_cnt, val_cnt);
        end
    endtask

    task automatic test_loop();
        obs_t o, e;
        int   done_cnt;
        done_cnt = 0;
        begin_sweep(2, 8, 1'b1);
        for (int t = 0; t <= 45; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL loop t=%0d got %h exp %h", t, o, e);
            end
            if (o.done) done_cnt++;
            m_hold = e;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL loop_no_done count=%0d exp 0", done_cnt);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        e = frozen(m_hold);
        o = dut_obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL loop_abort got %h exp %h", o, e);
        end
        m_hold = e;
    endtask

    task automatic test_abort();
        obs_t o, e;
        begin_sweep(2, 8, 1'b0);
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL abort_pre t=%0d got %h exp %h", t, o, e);
            end
            m_hold = e;
        end
        // Third DWELL cycle of step 1 is sampled at edge 21.
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        e = frozen(m_hold);
        o = dut_obs();
        checks++;
        if (o !== e || o.fc1 !== 16'd20) begin
            errors++;
            $display("FAIL abort_freeze got %h exp %h", o, e);
        end
        m_hold = e;
        repeat (5) tick();
        o = dut_obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_idle got %h exp %h", o, e);
        end
        // Abort while idle blocks a simultaneous start.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tick();
        o = dut_obs();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL abort_blocks_start got %h exp %h", o, e);
        end
    endtask

    // Writes, starts and parameter changes during a sweep must all be ignored.
    task automatic test_busy_ignore();
        obs_t o, e;
        begin_sweep(2, 3, 1'b0);
        for (int t = 0; t <= 26; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy_ignore t=%0d got %h exp %h", t, o, e);
            end
            m_hold = e;
            if (t + 1 < 3 * 8) begin
                noise();
                if (t == 5) begin
                    bus.cfg_we   = 1'b1;
                    bus.cfg_addr = '0;
                    bus.cfg_fc1  = 16'd999;
                    bus.cfg_fc2  = 16'd999;
                end
            end else begin
                drive_quiet();
            end
        end
        drive_quiet();
    endtask

    // dwell_len=0 gives a single-cycle window; entry 0 still holds (10,100).
    task automatic test_dwell_zero();
        obs_t o, e;
        int   val_cnt;
        val_cnt = 0;
        begin_sweep(0, 0, 1'b0);
        for (int t = 0; t <= 8; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL dwell_zero t=%0d got %h exp %h", t, o, e);
            end
            if (o.valid) val_cnt++;
            m_hold = e;
        end
        checks++;
        if (val_cnt !== 1 || m_hold.fc1 !== 16'd10 || bus.fre_cnt1 !== 16'd10) begin
            errors++;
            $display("FAIL dwell_zero_window valid=%0d fc1=%0d exp valid=1 fc1=10", val_cnt, bus.fre_cnt1);
        end
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        begin_sweep(1, 5, 1'b0);
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_reset t=%0d got %h exp %h", t, o, e);
            end
        end
        #3 reset_p = 1'b1;
        #1;
        o = dut_obs();
        checks++;
        if (o !== reset_obs()) begin
            errors++;
            $display("FAIL async_reset got %h exp %h", o, reset_obs());
        end
        @(posedge clk_in);
        #1 reset_p = 1'b0;
        model_reset();
        tick();
        begin_sweep(2, 1, 1'b0);
        for (int t = 0; t <= 20; t++) begin
            if (t > 0) tick();
            e = exp_at(t);
            o = dut_obs();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_table t=%0d got %h exp %h", t, o, e);
            end
            m_hold = e;
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int   last, dwell, nwr, plen, total, abort_t;
        bit   lp;
        for (int it = 0; it < 8; it++) begin
            nwr = $urandom_range(1, 3);
            for (int w = 0; w < nwr; w++)
                write_entry($urandom_range(0, DEPTH - 1), 16'($urandom), 16'($urandom));
            last  = $urandom_range(0, DEPTH - 1);
            dwell = $urandom_range(0, 6);
            lp    = 1'($urandom);
            plen  = 1 + SETTLE_CYC + ((dwell == 0) ? 1 : dwell);
            if (lp)                 abort_t = $urandom_range(1, 2 * (last + 1) * plen);
            else if (1'($urandom))  abort_t = $urandom_range(1, (last + 1) * plen);
            else                    abort_t = 0;
            total = (abort_t > 0) ? abort_t : (last + 1) * plen + 2;
            begin_sweep(last, dwell, lp);
            for (int t = 0; t <= total; t++) begin
                if (t > 0) tick();
                e = (abort_t > 0 && t == abort_t) ? frozen(m_hold) : exp_at(t);
                o = dut_obs();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL random it=%0d t=%0d got %h exp %h", it, t, o, e);
                end
                m_hold = e;
                if (t + 1 == abort_t) begin
                    drive_quiet();
                    bus.abort = 1'b1;
                end else if (t < total && (lp || t + 1 < (last + 1) * plen)) begin
                    noise();
                end else begin
                    drive_quiet();
                end
            end
            drive_quiet();
            tick();
        end
    endtask

`ifdef SWEEP_EXT_ADV_EN
    task automatic test_adv();
        int t_r;
        t_r = -1;
        write_entry(0, 16'd10, 16'd100);
        write_entry(1, 16'd20, 16'd200);
        begin_sweep(1, 8, 1'b0);
        for (int t = 1; t <= 20 && t_r < 0; t++) begin
            tick();
            if (bus.step_valid) t_r = t;
        end
        checks++;
        if (t_r !== 1 + SETTLE_CYC) begin
            errors++;
            $display("FAIL adv_valid_rise at=%0d exp %0d", t_r, 1 + SETTLE_CYC);
        end
        repeat (4) tick();
        checks++;
        if (bus.step_valid !== 1'b1) begin
            errors++;
            $display("FAIL adv_hold valid=%0b exp 1", bus.step_valid);
        end
        bus.adv = 1'b1;
        tick();
        bus.adv = 1'b0;
        checks++;
        if (bus.step_valid !== 1'b0) begin
            errors++;
            $display("FAIL adv_drop valid=%0b exp 0", bus.step_valid);
        end
        tick();
        checks++;
        if (bus.fre_cnt1 !== 16'd20 || bus.gen_rst !== 1'b1 || bus.step_idx !== 3'd1) begin
            errors++;
            $display("FAIL adv_next fc1=%0d gen=%0b idx=%0d exp fc1=20 gen=1 idx=1",
                     bus.fre_cnt1, bus.gen_rst, bus.step_idx);
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask
`endif

    initial begin
        drive_quiet();
        test_reset();
`ifdef SWEEP_EXT_ADV_EN
        test_adv();
`else
        test_default_table();
        test_single_shot();
        test_loop();
        test_abort();
        test_busy_ignore();
        test_dwell_zero();
        test_async_reset();
        test_random();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
